innings_scorer: RTL and testbench

- Parametrised successor to the single-innings scoreboard.
- Tracks score, wickets, overs, balls-in-over, extras and striker end for one innings from a stream of delivery events.
- Adds a valid/ready event handshake, an IDLE/PLAY/DONE innings state machine, configurable over and wicket limits, and saturating arithmetic.
- Sits between the operator/event-decode front end and the display driver.

---
 rtl/innings_scorer.sv | 185 ++++++++++++++++++
 tb/tb_innings_scorer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/innings_scorer.sv
// Single-innings cricket scorer: valid/ready delivery events drive an IDLE/PLAY/DONE FSM.
// Optional chase target check enabled by defining INNINGS_SCORER_TARGET_EN.
module innings_scorer #(
  parameter int BALLS_PER_OVER = 6,
  parameter int MAX_OVERS      = 20,
  parameter int MAX_WICKETS    = 10,
  parameter int SCORE_W        = 9,
  parameter int OVER_W         = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic [1:0]         evt_type,
  input  logic [2:0]         evt_runs,
`ifdef INNINGS_SCORER_TARGET_EN
  input  logic [SCORE_W-1:0] target,
`endif
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] extras,
  output logic [3:0]         wickets,
  output logic [OVER_W-1:0]  overs,
  output logic [3:0]         balls,
  output logic               striker,
  output logic               innings_done,
  output logic [1:0]         done_reason,
  output logic               evt_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0]        EVT_LEGAL  = 2'd0;
  localparam logic [1:0]        EVT_WIDE   = 2'd1;
  localparam logic [1:0]        EVT_NOBALL = 2'd2;
  localparam logic [1:0]        EVT_WICKET = 2'd3;
  localparam logic [3:0]        LAST_BALL  = 4'(BALLS_PER_OVER - 1);
  localparam logic [3:0]        WKT_LIM    = 4'(MAX_WICKETS);
  localparam logic [OVER_W-1:0] OVR_LIM    = OVER_W'(MAX_OVERS);

  // Saturating add: a carry out of the counter clamps it at all-ones.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {{(SCORE_W-3){1'b0}}, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d, extras_q, extras_d;
  logic [3:0]         wickets_q, wickets_d, balls_q, balls_d;
  logic [OVER_W-1:0]  overs_q, overs_d;
  logic               striker_q, striker_d, err_q, err_d;
  logic [1:0]         reason_q, reason_d;
  logic               ready_s, accept_s, counts_s, over_done_s, target_hit_s;
  logic [3:0]         runs_s;

  assign ready_s  = (state_q == ST_PLAY) && !start;
  assign accept_s = evt_valid && ready_s;
  assign runs_s   = {1'b0, evt_runs};

  // Next-state: start clears everything; otherwise an accepted event updates the tallies.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    extras_d     = extras_q;
    wickets_d    = wickets_q;
    balls_d      = balls_q;
    overs_d      = overs_q;
    striker_d    = striker_q;
    reason_d     = reason_q;
    err_d        = 1'b0;
    counts_s     = 1'b0;
    over_done_s  = 1'b0;
    target_hit_s = 1'b0;
    if (start) begin
      state_d   = ST_PLAY;
      score_d   = '0;
      extras_d  = '0;
      wickets_d = 4'd0;
      balls_d   = 4'd0;
      overs_d   = '0;
      striker_d = 1'b0;
      reason_d  = 2'd0;
    end else if (accept_s) begin
      if (evt_runs == 3'd7) begin
        err_d = 1'b1;
      end else begin
        case (evt_type)
          EVT_LEGAL: begin
            score_d  = sat_add(score_q, runs_s);
            counts_s = 1'b1;
          end
          EVT_WIDE: begin
            score_d  = sat_add(score_q, runs_s + 4'd1);
            extras_d = sat_add(extras_q, runs_s + 4'd1);
          end
          EVT_NOBALL: begin
            score_d  = sat_add(score_q, runs_s + 4'd1);
            extras_d = sat_add(extras_q, 4'd1);
          end
          EVT_WICKET: begin
            score_d   = sat_add(score_q, runs_s);
            wickets_d = wickets_q + 4'd1;
            counts_s  = 1'b1;
          end
          default: begin
            counts_s = 1'b0;
          end
        endcase
        over_done_s = counts_s && (balls_q >= LAST_BALL);
        if (over_done_s) begin
          balls_d = 4'd0;
          overs_d = overs_q + OVER_W'(1);
        end else if (counts_s) begin
          balls_d = balls_q + 4'd1;
        end else begin
          balls_d = balls_q;
        end
        // Odd runs swap ends, and so does the change of over; together they cancel.
        striker_d = striker_q ^ evt_runs[0] ^ over_done_s;
      end
`ifdef INNINGS_SCORER_TARGET_EN
      target_hit_s = (target != '0) && (score_d >= target);
`else
      target_hit_s = 1'b0;
`endif
      if (target_hit_s) begin
        state_d  = ST_DONE;
        reason_d = 2'd3;
      end else if (wickets_d == WKT_LIM) begin
        state_d  = ST_DONE;
        reason_d = 2'd1;
      end else if (overs_d == OVR_LIM) begin
        state_d  = ST_DONE;
        reason_d = 2'd2;
      end else begin
        state_d  = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      extras_q  <= '0;
      wickets_q <= 4'd0;
      balls_q   <= 4'd0;
      overs_q   <= '0;
      striker_q <= 1'b0;
      reason_q  <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      extras_q  <= extras_d;
      wickets_q <= wickets_d;
      balls_q   <= balls_d;
      overs_q   <= overs_d;
      striker_q <= striker_d;
      reason_q  <= reason_d;
      err_q     <= err_d;
    end
  end

  assign evt_ready    = ready_s;
  assign score        = score_q;
  assign extras       = extras_q;
  assign wickets      = wickets_q;
  assign overs        = overs_q;
  assign balls        = balls_q;
  assign striker      = striker_q;
  assign innings_done = (state_q == ST_DONE);
  assign done_reason  = reason_q;
  assign evt_err      = err_q;

endmodule

// File: tb/tb_innings_scorer.sv
// Table-driven scoreboard bench for innings_scorer; instance a uses default limits,
// instance b uses MAX_OVERS=1, MAX_WICKETS=1.
module tb_innings_scorer;

  typedef struct packed {
    logic [8:0] score;
    logic [8:0] extras;
    logic [3:0] wickets;
    logic [4:0] overs;
    logic [3:0] balls;
    logic       striker;
    logic       done;
    logic [1:0] reason;
    logic       err;
  } out_t;

  typedef struct {
    logic       sel;
    logic       start;
    logic       valid;
    logic [1:0] typ;
    logic [2:0] runs;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, valid_a = 1'b0, valid_b = 1'b0;
  logic [1:0] evt_type = 2'd0;
  logic [2:0] evt_runs = 3'd0;
  logic [8:0] target = 9'd0;
  logic       ready_a, ready_b;
  logic [8:0] score_a, extras_a, score_b, extras_b;
  logic [3:0] wickets_a, balls_a, wickets_b, balls_b;
  logic [4:0] overs_a, overs_b;
  logic       striker_a, done_a, err_a, striker_b, done_b, err_b;
  logic [1:0] reason_a, reason_b;
  out_t       act_a, act_b;

  int n_chk = 0, n_fail = 0, vec_idx = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  innings_scorer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .evt_valid(valid_a), .evt_ready(ready_a),
    .evt_type(evt_type), .evt_runs(evt_runs),
`ifdef INNINGS_SCORER_TARGET_EN
    .target(target),
`endif
    .score(score_a), .extras(extras_a), .wickets(wickets_a), .overs(overs_a), .balls(balls_a),
    .striker(striker_a), .innings_done(done_a), .done_reason(reason_a), .evt_err(err_a)
  );

  innings_scorer #(.MAX_OVERS(1), .MAX_WICKETS(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .evt_valid(valid_b), .evt_ready(ready_b),
    .evt_type(evt_type), .evt_runs(evt_runs),
`ifdef INNINGS_SCORER_TARGET_EN
    .target(9'd0),
`endif
    .score(score_b), .extras(extras_b), .wickets(wickets_b), .overs(overs_b), .balls(balls_b),
    .striker(striker_b), .innings_done(done_b), .done_reason(reason_b), .evt_err(err_b)
  );

  assign act_a = {score_a, extras_a, wickets_a, overs_a, balls_a, striker_a, done_a, reason_a, err_a};
  assign act_b = {score_b, extras_b, wickets_b, overs_b, balls_b, striker_b, done_b, reason_b, err_b};

  function automatic vec_t mk(input logic sel, input logic st, input logic vl,
                              input logic [1:0] ty, input logic [2:0] rn,
                              input int sc, input int ex, input int wk, input int ov,
                              input int bl, input int sk, input int dn, input int rs,
                              input int er);
    vec_t v;
    v.sel = sel; v.start = st; v.valid = vl; v.typ = ty; v.runs = rn;
    v.exp.score   = 9'(sc);  v.exp.extras = 9'(ex);  v.exp.wickets = 4'(wk);
    v.exp.overs   = 5'(ov);  v.exp.balls  = 4'(bl);  v.exp.striker = 1'(sk);
    v.exp.done    = 1'(dn);  v.exp.reason = 2'(rs);  v.exp.err     = 1'(er);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it with the selected instance's outputs.
  task automatic check_out();
    vec_t e;
    out_t act;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: actual=empty required=entry");
    end else begin
      e = exp_q.pop_front();
      act = e.sel ? act_b : act_a;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL vec%0d: actual=%h required=%h", vec_idx, act, e.exp);
      end
    end
    vec_idx++;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    start_a  = v.start & ~v.sel;
    start_b  = v.start & v.sel;
    valid_a  = v.valid & ~v.sel;
    valid_b  = v.valid & v.sel;
    evt_type = v.typ;
    evt_runs = v.runs;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle();
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
  endtask

  initial begin
    // sel, start, valid, type, runs | score, extras, wkts, overs, balls, striker, done, reason, err
    tbl.push_back(mk(0,0,1,2'd0,3'd4, 0,0,0,0,0,0,0,0,0));   // IDLE ignores events
    tbl.push_back(mk(0,1,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'd0,3'd1, 1,0,0,0,1,1,0,0,0));
    tbl.push_back(mk(0,0,1,2'd0,3'd1, 2,0,0,0,2,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'd0,3'd1, 3,0,0,0,3,1,0,0,0));
    tbl.push_back(mk(0,0,1,2'd0,3'd1, 4,0,0,0,4,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'd0,3'd1, 5,0,0,0,5,1,0,0,0));
    // sixth single and the change of ends cancel, so end 1 keeps strike
    tbl.push_back(mk(0,0,1,2'd0,3'd1, 6,0,0,1,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'd1,3'd0, 1,1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'd2,3'd4, 6,2,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,2'd1,3'd3, 10,6,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,0,1,2'd0,3'd7, 10,6,0,0,0,1,0,0,1));  // illegal runs
    tbl.push_back(mk(0,0,0,2'd0,3'd0, 10,6,0,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,1,2'd0,3'd1, 0,0,0,0,0,0,0,0,0));   // start beats event
    tbl.push_back(mk(0,0,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(0,0,1,2'd3,3'd0, 0,0,k,(k >= 6) ? 1 : 0,(k >= 6) ? k-6 : k,
                       (k >= 6) ? 1 : 0,(k == 10) ? 1 : 0,(k == 10) ? 1 : 0,0));
    tbl.push_back(mk(0,0,1,2'd0,3'd4, 0,0,10,1,4,1,1,1,0));  // frozen in DONE

    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("reset_out", 32'(act_a), 32'd0);
    chk("reset_ready", 32'(ready_a), 32'd0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    idle();
    #1;
    chk("done_ready", 32'(ready_a), 32'd0);

    // DONE -> start -> PLAY, then handshake: start masks ready combinationally
    apply(mk(0,1,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    idle();
    valid_a = 1'b1; start_a = 1'b1;
    #1;
    chk("ready_with_start", 32'(ready_a), 32'd0);
    start_a = 1'b0;
    #1;
    chk("ready_in_play", 32'(ready_a), 32'd1);
    valid_a = 1'b0;

    // Saturation: wides worth 7 each reach 511 after 73, then clamp
    for (int i = 1; i <= 75; i++)
      apply(mk(0,0,1,2'd1,3'd6, (7*i > 511) ? 511 : 7*i, (7*i > 511) ? 511 : 7*i,
               0,0,0,0,0,0,0));
    apply(mk(0,0,1,2'd2,3'd6, 511,511,0,0,0,0,0,0,0));

    // Instance b: wicket on the over's last ball -> all-out wins over overs-complete
    apply(mk(1,1,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    for (int i = 1; i <= 5; i++) apply(mk(1,0,1,2'd0,3'd0, 0,0,0,0,i,0,0,0,0));
    apply(mk(1,0,1,2'd3,3'd0, 0,0,1,1,0,1,1,1,0));
    idle();
    #1;
    chk("b_done_ready", 32'(ready_b), 32'd0);
    apply(mk(1,1,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    for (int i = 1; i <= 5; i++) apply(mk(1,0,1,2'd0,3'd2, 2*i,0,0,0,i,0,0,0,0));
    apply(mk(1,0,1,2'd0,3'd2, 12,0,0,1,0,1,1,2,0));

`ifdef INNINGS_SCORER_TARGET_EN
    target = 9'd8;
    apply(mk(0,1,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    apply(mk(0,0,1,2'd0,3'd6, 6,0,0,0,1,0,0,0,0));
    apply(mk(0,0,1,2'd0,3'd2, 8,0,0,0,2,0,1,3,0));
    target = 9'd0;
`endif

    // Reset mid-innings clears without a clock edge
    apply(mk(0,1,0,2'd0,3'd0, 0,0,0,0,0,0,0,0,0));
    apply(mk(0,0,1,2'd0,3'd1, 1,0,0,0,1,1,0,0,0));
    idle();
    valid_a = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_out", 32'(act_a), 32'd0);
    chk("async_reset_ready", 32'(ready_a), 32'd0);
    valid_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0,0,1,2'd0,3'd3, 0,0,0,0,0,0,0,0,0));  // still IDLE after reset
    idle();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
